// File: rtl/pixel_frame_assembler_pkg.sv
// Shared definitions for the pooling pipeline: assembler FSM states and
// counter sizing.
package pixel_frame_assembler_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Width of a 0..n-1 index counter, never narrower than one bit
    function automatic int cnt_w_f(input int n);
        if (n < 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/pixel_frame_assembler.sv
// Packs a raster-order pixel stream into one flat frame vector and holds it
// under a valid/ready handshake; pix_sof resynchronises a broken stream.
module pixel_frame_assembler
    import pixel_frame_assembler_pkg::*;
#(
    parameter int resolution    = 8,
    parameter int pixels_number = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [resolution-1:0]               pix_in,
    input  logic                                pix_valid,
    input  logic                                pix_sof,
    output logic                                pix_ready,
    output logic [resolution*pixels_number-1:0] frame_out,
    output logic                                frame_valid,
    input  logic                                frame_ready,
    output logic                                frame_error
);

    localparam int                 CNT_W    = cnt_w_f(pixels_number);
    localparam int                 FRAME_W  = resolution * pixels_number;
    localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(pixels_number - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               valid_q, valid_d;
    logic               error_q, error_d;

    logic               accept_s;
    logic               wr_en_s;
    logic [CNT_W-1:0]   wr_idx_s;

    // Ready depends only on registered state, so no path from frame_ready
    assign pix_ready = (state_q == FILL) && !reset;
    assign accept_s  = pix_valid && pix_ready;

    // Next-state, index and write-enable decode for the FILL/HOLD FSM
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        error_d  = 1'b0;
        wr_en_s  = 1'b0;
        wr_idx_s = idx_q;
        case (state_q)
            FILL: begin
                if (accept_s) begin
                    wr_en_s = 1'b1;
                    if (pix_sof) begin
                        // Restart at slot 0; stale slots get overwritten later
                        wr_idx_s = {CNT_W{1'b0}};
                        idx_d    = CNT_W'(1);
                        error_d  = (idx_q != {CNT_W{1'b0}});
                    end else if (idx_q == LAST_IDX) begin
                        idx_d   = {CNT_W{1'b0}};
                        state_d = HOLD;
                        valid_d = 1'b1;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            HOLD: begin
                if (valid_q && frame_ready) begin
                    valid_d = 1'b0;
                    state_d = FILL;
                end else begin
                    valid_d = valid_q;
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = FILL;
                idx_d   = {CNT_W{1'b0}};
                valid_d = 1'b0;
            end
        endcase
    end

    // Slot write: only the addressed pixel lane changes, others keep stale data
    always_comb begin
        frame_d = frame_q;
        for (int k = 0; k < pixels_number; k++) begin
            if (wr_en_s && (wr_idx_s == CNT_W'(k))) begin
                frame_d[k*resolution +: resolution] = pix_in;
            end else begin
                frame_d[k*resolution +: resolution] = frame_q[k*resolution +: resolution];
            end
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
            idx_q   <= {CNT_W{1'b0}};
            frame_q <= {FRAME_W{1'b0}};
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    assign frame_out   = frame_q;
    assign frame_valid = valid_q;
    assign frame_error = error_q;

endmodule

// File: tb/tb_pixel_frame_assembler.sv
// Randomised and directed bench for pixel_frame_assembler against a
// slot-array reference model.
module tb_pixel_frame_assembler;

    localparam int RES = 8;
    localparam int PN  = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [RES-1:0]   pix_in;
    logic             pix_valid;
    logic             pix_sof;
    logic             pix_ready;
    logic [RES*PN-1:0] frame_out;
    logic             frame_valid;
    logic             frame_ready;
    logic             frame_error;

    pixel_frame_assembler #(.resolution(RES), .pixels_number(PN)) dut (
        .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_sof(pix_sof), .pix_ready(pix_ready), .frame_out(frame_out),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int err_pulses = 0;
    int rise_q[$];

    // Reference model: frame as an array of pixels plus fill count
    logic [RES-1:0] m_buf[PN];
    int             m_n = 0;
    bit             m_hold = 1'b0;
    bit             m_err = 1'b0;

    function automatic logic [RES*PN-1:0] m_vec();
        logic [RES*PN-1:0] v;
        for (int k = 0; k < PN; k++) v[k*RES +: RES] = m_buf[k];
        return v;
    endfunction

    task automatic chk(input string name, input logic [RES*PN-1:0] act, input logic [RES*PN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycle(input bit v, input bit sof, input logic [RES-1:0] d,
                         input bit fr, input bit rst, output bit acc);
        bit was_hold;
        pix_valid = v; pix_sof = sof; pix_in = d; frame_ready = fr; reset = rst;
        #1;
        chk("pix_ready", pix_ready, (!m_hold && !rst));
        acc = v && !m_hold && !rst;
        @(posedge clk);
        #1;
        cyc++;
        was_hold = m_hold;
        m_err = 1'b0;
        if (rst) begin
            for (int k = 0; k < PN; k++) m_buf[k] = '0;
            m_n = 0;
            m_hold = 1'b0;
        end else if (m_hold) begin
            if (fr) m_hold = 1'b0;
        end else if (acc) begin
            if (sof) begin
                m_err = (m_n != 0);
                m_buf[0] = d;
                m_n = 1;
            end else begin
                m_buf[m_n] = d;
                m_n++;
                if (m_n == PN) begin
                    m_n = 0;
                    m_hold = 1'b1;
                end
            end
        end
        chk("frame_valid", frame_valid, m_hold);
        chk("frame_error", frame_error, m_err);
        chk("frame_out", frame_out, m_vec());
        if (!was_hold && m_hold) rise_q.push_back(cyc);
        if (frame_error) err_pulses++;
    endtask

    // Present pixels until n are accepted; ramp adds the accepted index
    task automatic feed(input int n, input logic [RES-1:0] base, input bit ramp,
                        input int bubble_pct, input bit fr);
        int k = 0;
        int budget = 0;
        bit acc;
        bit v;
        while (k < n && budget < 400) begin
            v = ($urandom_range(99) >= bubble_pct);
            cycle(v, 1'b0, ramp ? RES'(int'(base) + k) : base, fr, 1'b0, acc);
            if (acc) k++;
            budget++;
        end
        if (k < n) chk("feed_budget", k, n);
    endtask

    initial begin
        bit acc;
        int e0;
        int r0;
        logic [RES*PN-1:0] snap;

        for (int k = 0; k < PN; k++) m_buf[k] = '0;
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, acc);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, acc);
        chk("reset_frame_out", frame_out, '0);
        chk("reset_valid", frame_valid, 1'b0);

        // All-fives frame with consumer always ready
        feed(16, 8'h05, 1'b0, 0, 1'b1);
        chk("t1_valid", frame_valid, 1'b1);
        chk("t1_frame", frame_out, 128'h05050505_05050505_05050505_05050505);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, acc);
        chk("t1_ready_after", pix_ready, 1'b1);

        // Ramp with bubbles
        e0 = err_pulses;
        feed(16, 8'h00, 1'b1, 30, 1'b0);
        for (int k = 0; k < PN; k++) chk("t2_slot", frame_out[k*RES +: RES], k);
        chk("t2_no_error", err_pulses, e0);

        // Consumer stalls for 20 cycles while the source keeps offering
        snap = frame_out;
        r0 = rise_q.size();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0, 8'h77, 1'b0, 1'b0, acc);
            chk("t3_no_accept", acc, 1'b0);
            chk("t3_stable", frame_out, snap);
            chk("t3_valid", frame_valid, 1'b1);
        end
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, acc);
        chk("t3_released", frame_valid, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, acc);
        chk("t3_single_hs", frame_valid, 1'b0);
        chk("t3_no_new_frame", rise_q.size(), r0);

        // Early start-of-frame discards a partial frame
        feed(7, 8'hAA, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, acc);
        chk("t4_error_pulse", frame_error, 1'b1);
        feed(15, 8'h22, 1'b0, 0, 1'b0);
        chk("t4_valid", frame_valid, 1'b1);
        chk("t4_frame", frame_out, {{15{8'h22}}, 8'h11});
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, acc);

        // Reset in the middle of a fill
        feed(9, 8'h99, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b0, 8'h99, 1'b0, 1'b1, acc);
        chk("t5_frame_zero", frame_out, '0);
        chk("t5_valid_zero", frame_valid, 1'b0);
        feed(16, 8'h30, 1'b1, 0, 1'b0);
        chk("t5_valid", frame_valid, 1'b1);
        chk("t5_frame", frame_out, 128'h3f3e3d3c_3b3a3938_37363534_33323130);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, acc);

        // Back-to-back frames with frame_ready tied high
        rise_q.delete();
        feed(32, 8'h40, 1'b1, 0, 1'b1);
        chk("t6_frames", rise_q.size(), 2);
        if (rise_q.size() == 2) chk("t6_spacing", rise_q[1] - rise_q[0], 17);
        chk("t6_frame2", frame_out, 128'h5f5e5d5c_5b5a5958_57565554_53525150);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, acc);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(99) < 70, $urandom_range(15) == 0,
                  RES'($urandom), $urandom_range(99) < 40,
                  $urandom_range(299) == 0, acc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
